nibble_checksum: RTL and testbench
==================================

# nibble_checksum

Sequential 4-bit ones' complement checksum accumulator. It accepts a stream of nibbles over a valid/ready handshake and folds each nibble into a running sum using end-around-carry addition. When the packet ends, it publishes the complemented sum as the checksum. It sits directly downstream of the stream source and wraps the team's combinational 4-bit ones' complement adder, registering its Y output every accepted beat.

## Interface
- MAX_WORDS, default 15: maximum nibbles per packet (1..255); reaching it without `last` forces termination.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a packet; honoured only in IDLE.
- valid  input  1  `data` and `last` are presented this cycle.
- data  input  4  nibble to accumulate.
- last  input  1  qualifies the final nibble of the packet (sampled with `valid`).
- ready  output  1  block accepts a nibble this cycle (high only in ACCUM).
- busy  output  1  high in ACCUM and DONE.
- done  output  1  one-cycle pulse: packet closed, `checksum` valid.
- checksum  output  4  bitwise NOT of the final accumulator; held until the next `start`.
- count  output  8  nibbles accepted in the current or last packet.
- overflow  output  1  last packet was terminated by MAX_WORDS rather than `last`; held until next `start`.

## Operation
- States: IDLE, ACCUM, DONE.
- Reset values: state IDLE, acc 4'b0000, ready 0, busy 0, done 0, checksum 4'b0000, count 0, overflow 0.
- **IDLE:**
  - `start` clears acc, count and overflow, then moves to ACCUM.
  - `valid` is ignored.
- **ACCUM:**
  - ready=1. A beat is accepted when valid&ready.
  - On an accepted beat: acc <= acc +1c data (4-bit sum, carry-out added back into bit 0), and count <= count+1.
  - If the beat has last=1, or count+1 == MAX_WORDS, move to DONE.
  - overflow <= 1 only on the MAX_WORDS exit without `last`.
  - `start` is ignored.
- **DONE:**
  - Lasts one cycle: done=1 and ready=0; the state then moves to IDLE.
  - checksum is loaded with ~acc on the transition into DONE.
- Arithmetic rules:
  - 1111 is negative zero and is a legal accumulator value; it is never normalised.
  - The second carry of the end-around add is discarded; it is provably zero.
  - count saturates only via the MAX_WORDS exit, so it never wraps.
- Reset asserted mid-packet: all state returns to reset values immediately; any partial sum is lost and no done pulse occurs.

## Timing
- Single-cycle accept: a beat accepted in cycle N is reflected in acc after the rising edge ending N.
- Last beat accepted in cycle N: done=1 and checksum valid in cycle N+1; ready=1 again only after a new `start`.
- start in cycle N: ready=1 in cycle N+1.
- Back-to-back beats at full rate (one per cycle) are supported; no bubbles are inserted.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- CHECKSUM_VERIFY_EN defined: adds output `ok` (1 bit, reset 0).
  - On entering DONE, ok <= (acc +1c data_last == 4'b1111), where acc already includes all beats, i.e. ok = (final acc == 4'b1111).
  - This lets a receiver send payload plus transmitted checksum and check for negative zero.
  - `ok` is held until the next `start`.
- Undefined: no `ok` port and no compare logic; all other behaviour is identical.

## Structure
- Shared package nibble_pkg:
  - state enum {IDLE, ACCUM, DONE}
  - NIBBLE_W=4
  - COUNT_W=8
  - NEG_ZERO=4'b1111
- One sub-module: ones_compliment, the existing combinational 4-bit end-around-carry adder. It is instanced with A=acc, B=data; its Y feeds the acc register.
- FSM, counter and output registers live in nibble_checksum.

## Test plan
- Reset, then start; beats 3, 5, 6 (last on 6) -> acc 1110, done pulse one cycle after the 6 beat, checksum 0001, count 3, overflow 0.
- Wrap-around: start; beats 1010, 1001(last) -> acc 0100 via end-around carry, checksum 1011.
- Overflow with MAX_WORDS=4: start; five valid beats of 0001, none with last -> only 4 accepted, ready drops, done pulse, overflow 1, count 4, checksum 1011.
- Handshake: valid toggled 1,0,1,0 with beats 2, 7(last); start pulsed during ACCUM -> start ignored, acc 1001, checksum 0110, no extra beats counted.
- Reset mid-packet: assert reset after 2 beats -> all outputs 0 next sample, no done; a fresh packet afterwards computes correctly.
- With CHECKSUM_VERIFY_EN: beats 3, 5, 6, 0001(last) -> acc 1111, ok 1; repeat with final beat 0010 -> ok 0.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble ones' complement checksum block.
package nibble_pkg;
  localparam int NIBBLE_W = 4;
  localparam int COUNT_W  = 8;
  localparam logic [NIBBLE_W-1:0] NEG_ZERO = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/ones_compliment.sv
// Combinational 4-bit ones' complement adder with end-around carry.
module ones_compliment
  import nibble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  output logic [NIBBLE_W-1:0] Y
);
  logic [NIBBLE_W:0] raw;

  assign raw = {1'b0, A} + {1'b0, B};
  // Folding the carry back in cannot carry out again, so 4 bits suffice.
  assign Y = raw[NIBBLE_W-1:0] + {{(NIBBLE_W-1){1'b0}}, raw[NIBBLE_W]};
endmodule

// File: rtl/nibble_checksum.sv
// Streaming nibble ones' complement checksum accumulator (IDLE/ACCUM/DONE).
// Optional `ok` negative-zero compare output when CHECKSUM_VERIFY_EN is defined.
module nibble_checksum
  import nibble_pkg::*;
#(
  parameter int MAX_WORDS = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                valid,
  input  logic [NIBBLE_W-1:0] data,
  input  logic                last,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [NIBBLE_W-1:0] checksum,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
`ifdef CHECKSUM_VERIFY_EN
  ,
  output logic                ok
`endif
);
  state_e              state_q;
  logic [NIBBLE_W-1:0] acc_q, acc_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [NIBBLE_W-1:0] checksum_q;
  logic                ready_q, busy_q, done_q, overflow_q;
  logic                accept, hit_max;

  ones_compliment u_add (
    .A(acc_q),
    .B(data),
    .Y(acc_d)
  );

  assign count_d = count_q + 1'b1;
  assign accept  = (state_q == ACCUM) && valid;
  assign hit_max = (count_d == COUNT_W'(MAX_WORDS));

`ifdef CHECKSUM_VERIFY_EN
  logic ok_q;
  assign ok = ok_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef CHECKSUM_VERIFY_EN
      ok_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            if (last || hit_max) begin
              state_q    <= DONE;
              ready_q    <= 1'b0;
              done_q     <= 1'b1;
              checksum_q <= ~acc_d;
              overflow_q <= !last;
`ifdef CHECKSUM_VERIFY_EN
              ok_q       <= (acc_d == NEG_ZERO);
`endif
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;
  assign count    = count_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_nibble_checksum.sv
// Self-checking bench for nibble_checksum against an arithmetic ones' complement model.
module tb_nibble_checksum;
  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] data = 4'd0;
  logic       last = 1'b0;
  logic       ready, busy, done, overflow;
  logic [3:0] checksum;
  logic [7:0] count;
`ifdef CHECKSUM_VERIFY_EN
  logic       ok;
`endif

  int checks = 0;
  int errors = 0;

  nibble_checksum #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .data(data), .last(last),
    .ready(ready), .busy(busy), .done(done), .checksum(checksum), .count(count),
    .overflow(overflow)
`ifdef CHECKSUM_VERIFY_EN
    , .ok(ok)
`endif
  );

  always #5 clk = ~clk;

  // Ones' complement addition in plain integer terms: sums past 15 wrap modulo 15.
  function automatic int oc_add(input int a, input int b);
    int s;
    s = a + b;
    if (s > 15) s = s - 15;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: ready=%b busy=%b required 1 1", ready, busy);
    end
  endtask

  // Drive one cycle with a beat presented; returns the done observed right after the edge.
  task automatic beat(input logic v, input logic [3:0] d, input logic l, output logic done_seen);
    valid = v;
    data  = d;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
    done_seen = done;
  endtask

  task automatic check_result(input string name, input int exp_acc, input int exp_cnt,
                              input logic exp_ovf);
    logic [3:0] exp_ck;
    exp_ck = ~exp_acc[3:0];
    checks++;
    if (checksum !== exp_ck || count !== exp_cnt[7:0] || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s: checksum=%b count=%0d ovf=%b required %b %0d %b",
               name, checksum, count, overflow, exp_ck, exp_cnt, exp_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ready !== 0 || busy !== 0 || done !== 0 || checksum !== 0 || count !== 0 || overflow !== 0) begin
      errors++;
      $display("FAIL reset_values: r=%b b=%b d=%b ck=%b cnt=%0d ov=%b required all 0",
               ready, busy, done, checksum, count, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic ds;
    do_start();
    beat(1, 4'd3, 0, ds);
    beat(1, 4'd5, 0, ds);
    checks++;
    if (ds !== 1'b0) begin errors++; $display("FAIL basic_early_done: done=%b required 0", ds); end
    beat(1, 4'd6, 1, ds);
    checks++;
    if (ds !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL basic_done: done=%b ready=%b required 1 0", ds, ready);
    end
    check_result("basic_result", 14, 3, 1'b0);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL basic_after: done=%b busy=%b ready=%b required 0 0 0", done, busy, ready);
    end
  endtask

  task automatic test_wrap();
    logic ds;
    do_start();
    beat(1, 4'b1010, 0, ds);
    beat(1, 4'b1001, 1, ds);
    checks++;
    if (ds !== 1'b1 || checksum !== 4'b1011) begin
      errors++; $display("FAIL wrap: done=%b checksum=%b required 1 1011", ds, checksum);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic ds;
    do_start();
    for (int i = 0; i < 3; i++) beat(1, 4'b0001, 0, ds);
    beat(1, 4'b0001, 0, ds);
    checks++;
    if (ds !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL ovf_done: done=%b ready=%b required 1 0", ds, ready);
    end
    check_result("ovf_result", 4, 4, 1'b1);
    beat(1, 4'b0001, 0, ds);
    checks++;
    if (count !== 8'd4 || ds !== 1'b0) begin
      errors++; $display("FAIL ovf_extra_beat: count=%0d done=%b required 4 0", count, ds);
    end
  endtask

  task automatic test_handshake();
    logic ds;
    do_start();
    beat(1, 4'd2, 0, ds);
    beat(0, 4'd15, 1, ds);
    start = 1'b1;
    beat(0, 4'd15, 0, ds);
    start = 1'b0;
    checks++;
    if (count !== 8'd1 || ready !== 1'b1) begin
      errors++; $display("FAIL hs_idle_beats: count=%0d ready=%b required 1 1", count, ready);
    end
    beat(1, 4'd7, 1, ds);
    checks++;
    if (ds !== 1'b1) begin errors++; $display("FAIL hs_done: done=%b required 1", ds); end
    check_result("hs_result", 9, 2, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    logic ds;
    bit   saw_done;
    do_start();
    beat(1, 4'd4, 0, ds);
    beat(1, 4'd9, 0, ds);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 0 || busy !== 0 || done !== 0 || checksum !== 0 || count !== 0 || overflow !== 0) begin
      errors++;
      $display("FAIL midreset_values: r=%b b=%b d=%b ck=%b cnt=%0d ov=%b required all 0",
               ready, busy, done, checksum, count, overflow);
    end
    tick();
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midreset_nodone: done pulse seen required none"); end
    do_start();
    beat(1, 4'd12, 0, ds);
    beat(1, 4'd11, 1, ds);
    check_result("midreset_fresh", oc_add(12, 11), 2, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      int   len, m_acc, m_cnt, idx, guard;
      bit   term, m_ovf;
      logic v, l, ds;
      logic [3:0] d;
      len = $urandom_range(1, 6);
      m_acc = 0; m_cnt = 0; idx = 0; term = 0; m_ovf = 0; guard = 0;
      do_start();
      while (!term && guard < 100) begin
        guard++;
        v = ($urandom_range(0, 3) != 0);
        d = 4'($urandom_range(0, 15));
        l = v && (idx == len - 1);
        beat(v, d, l, ds);
        if (v) begin
          m_acc = oc_add(m_acc, int'(d));
          m_cnt++;
          idx++;
          if (l) term = 1;
          else if (m_cnt == MAXW) begin term = 1; m_ovf = 1; end
        end
        checks++;
        if (ds !== logic'(term) || ready !== logic'(!term)) begin
          errors++;
          $display("FAIL rand_cycle p%0d: done=%b ready=%b required %b %b", p, ds, ready, term, !term);
        end
      end
      if (!term) begin
        errors++; $display("FAIL rand_timeout p%0d: packet never terminated", p);
      end
      check_result("rand_result", m_acc, m_cnt, m_ovf);
      tick();
    end
  endtask

`ifdef CHECKSUM_VERIFY_EN
  task automatic test_verify();
    logic ds;
    for (int k = 0; k < 2; k++) begin
      do_start();
      beat(1, 4'd3, 0, ds);
      beat(1, 4'd5, 0, ds);
      beat(1, 4'd6, 0, ds);
      beat(1, (k == 0) ? 4'b0001 : 4'b0010, 1, ds);
      checks++;
      if (ok !== ((k == 0) ? 1'b1 : 1'b0) || ds !== 1'b1) begin
        errors++; $display("FAIL verify_ok k%0d: ok=%b done=%b required %b 1", k, ok, ds, k == 0);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_handshake();
    test_reset_mid();
    test_random();
`ifdef CHECKSUM_VERIFY_EN
    test_verify();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
